// File: rtl/i2c_codec_responder.sv
// Write-only I2C responder for the WM8731 control port: ACKs 3-byte register
// writes and keeps a readable 9-bit register bank with codec reset defaults.
module i2c_codec_responder #(
  parameter logic [6:0]  DEV_ADDR    = 7'h1A,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i2c_sclk,
  input  logic       i2c_sdat_in,
  output logic       sda_pull_low,
  output logic       reg_wr_valid,
  output logic [6:0] reg_addr,
  output logic [8:0] reg_data,
  output logic       bad_addr,
  input  logic [3:0] rd_addr,
  output logic [8:0] rd_data
);

  typedef enum logic [2:0] {IDLE, DEV, ACK_DEV, B1, ACK1, B2, ACK2, IGNORE} state_t;

  localparam logic [8:0] BANK_DEF [10] = '{9'h097, 9'h097, 9'h079, 9'h079, 9'h00A,
                                           9'h008, 9'h09F, 9'h00A, 9'h000, 9'h000};

  logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
  logic                   scl_prev_q, sda_prev_q;
  logic                   scl_s, sda_s, scl_rise, scl_fall, start_evt, stop_evt;

  state_t      state_q, state_d;
  logic [7:0]  shift_q, shift_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        pull_q, pull_d;
  logic [6:0]  addr_q, addr_d;
  logic        d8_q, d8_d;
  logic        wr_q, wr_d;
  logic        bad_q, bad_d;
  logic [6:0]  raddr_q, raddr_d;
  logic [8:0]  rdata_q, rdata_d;
  logic [8:0]  bank_q [10];
  logic [8:0]  bank_d [10];
  logic [8:0]  commit_data;

  assign scl_s       = scl_sync_q[SYNC_STAGES-1];
  assign sda_s       = sda_sync_q[SYNC_STAGES-1];
  assign scl_rise    = scl_s & ~scl_prev_q;
  assign scl_fall    = ~scl_s & scl_prev_q;
  assign start_evt   = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
  assign stop_evt    = scl_s & scl_prev_q & ~sda_prev_q & sda_s;
  assign commit_data = {d8_q, shift_q};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
      state_q    <= IDLE;
      shift_q    <= '0;
      cnt_q      <= '0;
      pull_q     <= 1'b0;
      addr_q     <= '0;
      d8_q       <= 1'b0;
      wr_q       <= 1'b0;
      bad_q      <= 1'b0;
      raddr_q    <= '0;
      rdata_q    <= '0;
      bank_q     <= BANK_DEF;
    end else begin
      scl_sync_q[0] <= i2c_sclk;
      sda_sync_q[0] <= i2c_sdat_in;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
        scl_sync_q[i] <= scl_sync_q[i-1];
        sda_sync_q[i] <= sda_sync_q[i-1];
      end
      scl_prev_q <= scl_s;
      sda_prev_q <= sda_s;
      state_q    <= state_d;
      shift_q    <= shift_d;
      cnt_q      <= cnt_d;
      pull_q     <= pull_d;
      addr_q     <= addr_d;
      d8_q       <= d8_d;
      wr_q       <= wr_d;
      bad_q      <= bad_d;
      raddr_q    <= raddr_d;
      rdata_q    <= rdata_d;
      bank_q     <= bank_d;
    end
  end

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    pull_d  = pull_q;
    addr_d  = addr_q;
    d8_d    = d8_q;
    wr_d    = 1'b0;
    bad_d   = 1'b0;
    raddr_d = raddr_q;
    rdata_d = rdata_q;
    bank_d  = bank_q;
    if (stop_evt) begin
      state_d = IDLE;
      pull_d  = 1'b0;
      cnt_d   = '0;
    end else if (start_evt) begin
      state_d = DEV;
      pull_d  = 1'b0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        DEV, B1, B2: begin
          if (scl_rise && cnt_q < 4'd8) begin
            shift_d = {shift_q[6:0], sda_s};
            cnt_d   = cnt_q + 4'd1;
          end else if (scl_fall && cnt_q == 4'd8) begin
            cnt_d = '0;
            // Byte complete: the ACK (if any) starts on this falling edge.
            if (state_q == DEV) begin
              if (shift_q == {DEV_ADDR, 1'b0}) begin
                state_d = ACK_DEV;
                pull_d  = 1'b1;
              end else begin
                state_d = IGNORE;
              end
            end else if (state_q == B1) begin
              addr_d  = shift_q[7:1];
              d8_d    = shift_q[0];
              state_d = ACK1;
              pull_d  = 1'b1;
            end else begin
              state_d = ACK2;
              pull_d  = 1'b1;
              wr_d    = 1'b1;
              raddr_d = addr_q;
              rdata_d = commit_data;
              if (addr_q < 7'd10) bank_d[addr_q[3:0]] = commit_data;
              else if (addr_q == 7'd15) bank_d = BANK_DEF;
              else bad_d = 1'b1;
            end
          end
        end
        ACK_DEV, ACK1, ACK2: begin
          if (scl_fall) begin
            pull_d = 1'b0;
            cnt_d  = '0;
            state_d = (state_q == ACK_DEV) ? B1 : (state_q == ACK1) ? B2 : IGNORE;
          end
        end
        default: ;
      endcase
    end
  end

  assign sda_pull_low = pull_q;
  assign reg_wr_valid = wr_q;
  assign bad_addr     = bad_q;
  assign reg_addr     = raddr_q;
  assign reg_data     = rdata_q;
  assign rd_data      = (rd_addr < 4'd10) ? bank_q[rd_addr] : '0;

endmodule
